// File: rtl/serial_tx.sv
// serial_tx: valid/ready parallel-in, single-wire serial-out transmitter.
// Frame is start(0), DATA_W data bits LSB first, stop(1); each bit lasts CLK_DIV clocks.
module serial_tx #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic              tx_out_q;
  logic              frame_done_q;

  // Next data bit is taken from the shifted word so DATA_W=1 needs no special case.
  always_comb begin
    shift_d = shift_q >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (tx_valid) begin
          shift_q   <= tx_data;
          state_q   <= START;
          div_cnt_q <= '0;
          tx_out_q  <= 1'b0;
        end
      end else if (div_cnt_q == DIV_LAST) begin
        div_cnt_q <= '0;
        case (state_q)
          START: begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_out_q  <= shift_q[0];
          end
          DATA: begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q  <= STOP;
              tx_out_q <= 1'b1;
            end else begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              tx_out_q  <= shift_d[0];
            end
          end
          STOP: begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end else begin
        div_cnt_q <= div_cnt_q + DIV_W'(1);
      end
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_out     = tx_out_q;
  assign frame_done = frame_done_q;

endmodule
